// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and the data stage.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_done_o,
  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
  input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] dm_be_i,
  output logic [DATA_WIDTH-1:0]   dm_rdata_o,
  output logic                    dm_done_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    stall_f_o,
  output logic                    stall_m_o
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  // state | meaning
  // IDLE  | arbitrate pending requests
  // REQ   | request presented, waiting for grant
  // RSP   | granted, waiting for rvalid
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

  state_e                state_q, state_d;
  logic                  owner_if_q, owner_if_d;
  logic [2:0]            starve_q, starve_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  fetch_win;
  logic                  rsp_done;

  assign rsp_done = (state_q == RSP) && mem_rvalid_i;

  always_comb begin
    state_d    = state_q;
    owner_if_d = owner_if_q;
    starve_d   = starve_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    fetch_win  = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i || dm_req_i) begin
          fetch_win = !dm_req_i || (if_req_i && (starve_q == LIMIT));
          state_d   = REQ;
          if (fetch_win) begin
            owner_if_d = 1'b1;
            we_d       = 1'b0;
            addr_d     = if_addr_i;
            wdata_d    = '0;
            be_d       = '1;
            starve_d   = '0;
          end else begin
            owner_if_d = 1'b0;
            we_d       = dm_we_i;
            addr_d     = dm_addr_i;
            wdata_d    = dm_wdata_i;
            be_d       = dm_we_i ? dm_be_i : '1;
            if (!if_req_i)              starve_d = '0;
            else if (starve_q != LIMIT) starve_d = starve_q + 3'd1;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) state_d = RSP;
      end
      RSP: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (owner_if_q)  if_rdata_d = mem_rdata_i;
          else if (!we_q)  dm_rdata_d = mem_rdata_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      owner_if_q <= 1'b0;
      starve_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_if_q <= owner_if_d;
      starve_q   <= starve_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

  assign if_done_o  = rsp_done && owner_if_q;
  assign dm_done_o  = rsp_done && !owner_if_q;
  // Read data is forwarded in the done cycle; stores leave the held load data alone.
  assign if_rdata_o = if_done_o ? mem_rdata_i : if_rdata_q;
  assign dm_rdata_o = (dm_done_o && !we_q) ? mem_rdata_i : dm_rdata_q;

  assign stall_f_o = if_req_i && !if_done_o;
  assign stall_m_o = dm_req_i && !dm_done_o;

endmodule
